// File: rtl/spi_sequenciador.sv
// SPI transaction sequencer: frames a counted burst of bytes with chip select, setup/hold/gap timing.
// Optional macro SPI_SEQ_CONTADOR_EN adds the 16-bit completed-transaction counter output contador_trans.
module spi_sequenciador #(
    parameter int CICLOS_SETUP = 2,
    parameter int CICLOS_HOLD  = 2,
    parameter int CICLOS_GAP   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd_num_bytes,
    input  logic       cmd_valido,
    output logic       cmd_pronto,
    input  logic [7:0] in_dado,
    input  logic       in_valido,
    output logic       in_pronto,
    output logic [7:0] out_dado,
    output logic       out_valido,
    output logic [7:0] m_tx_dado,
    output logic       m_tx_valido,
    input  logic       m_tx_pronto,
    input  logic [7:0] m_rx_dado,
    input  logic       m_rx_valido,
    output logic       spi_cs_n,
`ifdef SPI_SEQ_CONTADOR_EN
    output logic [15:0] contador_trans,
`endif
    output logic       fim
);

    typedef enum logic [2:0] {
        OCIOSO,
        SETUP,
        ESPERA_DADO,
        ESPERA_RX,
        HOLD,
        GAP
    } estado_t;

    // Timers count down to zero, so they are loaded with (cycles - 1); zero-length phases are skipped.
    localparam logic [15:0] SETUP_INI = 16'((CICLOS_SETUP > 0) ? CICLOS_SETUP - 1 : 0);
    localparam logic [15:0] HOLD_INI  = 16'((CICLOS_HOLD  > 0) ? CICLOS_HOLD  - 1 : 0);
    localparam logic [15:0] GAP_INI   = 16'((CICLOS_GAP   > 0) ? CICLOS_GAP   - 1 : 0);

    estado_t     estado_q;
    logic [7:0]  restante_q;
    logic [15:0] tempo_q;
    logic        cs_n_q;
    logic        fim_q;
    logic        tx_valido_q;
    logic [7:0]  tx_dado_q;
    logic        out_valido_q;
    logic [7:0]  out_dado_q;

    assign cmd_pronto  = (estado_q == OCIOSO);
    assign in_pronto   = (estado_q == ESPERA_DADO) && m_tx_pronto;
    assign spi_cs_n    = cs_n_q;
    assign fim         = fim_q;
    assign m_tx_valido = tx_valido_q;
    assign m_tx_dado   = tx_dado_q;
    assign out_valido  = out_valido_q;
    assign out_dado    = out_dado_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q     <= OCIOSO;
            restante_q   <= 8'd0;
            tempo_q      <= 16'd0;
            cs_n_q       <= 1'b1;
            fim_q        <= 1'b0;
            tx_valido_q  <= 1'b0;
            tx_dado_q    <= 8'd0;
            out_valido_q <= 1'b0;
            out_dado_q   <= 8'd0;
        end else begin
            fim_q        <= 1'b0;
            tx_valido_q  <= 1'b0;
            out_valido_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (cmd_valido) begin
                        if (cmd_num_bytes == 8'd0) begin
                            fim_q <= 1'b1;
                        end else begin
                            restante_q <= cmd_num_bytes;
                            cs_n_q     <= 1'b0;
                            tempo_q    <= SETUP_INI;
                            estado_q   <= (CICLOS_SETUP == 0) ? ESPERA_DADO : SETUP;
                        end
                    end
                end
                SETUP: begin
                    if (tempo_q == 16'd0) estado_q <= ESPERA_DADO;
                    else                  tempo_q  <= tempo_q - 16'd1;
                end
                ESPERA_DADO: begin
                    if (in_valido && m_tx_pronto) begin
                        tx_dado_q   <= in_dado;
                        tx_valido_q <= 1'b1;
                        estado_q    <= ESPERA_RX;
                    end
                end
                ESPERA_RX: begin
                    if (m_rx_valido) begin
                        out_dado_q   <= m_rx_dado;
                        out_valido_q <= 1'b1;
                        restante_q   <= restante_q - 8'd1;
                        if (restante_q != 8'd1) begin
                            estado_q <= ESPERA_DADO;
                        end else if (CICLOS_HOLD == 0) begin
                            cs_n_q   <= 1'b1;
                            fim_q    <= 1'b1;
                            tempo_q  <= GAP_INI;
                            estado_q <= (CICLOS_GAP == 0) ? OCIOSO : GAP;
                        end else begin
                            tempo_q  <= HOLD_INI;
                            estado_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tempo_q == 16'd0) begin
                        cs_n_q   <= 1'b1;
                        fim_q    <= 1'b1;
                        tempo_q  <= GAP_INI;
                        estado_q <= (CICLOS_GAP == 0) ? OCIOSO : GAP;
                    end else begin
                        tempo_q <= tempo_q - 16'd1;
                    end
                end
                GAP: begin
                    if (tempo_q == 16'd0) estado_q <= OCIOSO;
                    else                  tempo_q  <= tempo_q - 16'd1;
                end
                default: estado_q <= OCIOSO;
            endcase
        end
    end

`ifdef SPI_SEQ_CONTADOR_EN
    logic [15:0] contador_q;

    // Counts each fim pulse the cycle after it is seen; wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst)        contador_q <= 16'd0;
        else if (fim_q) contador_q <= contador_q + 16'd1;
    end

    assign contador_trans = contador_q;
`endif

endmodule
